// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings and constants for the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_MEM_WAIT  = 3'd1,
    ST_IRQ_DRAIN = 3'd2,
    ST_IRQ_ENTER = 3'd3
  } state_t;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned DRAIN_DEPTH = 3;
  localparam int unsigned DRAIN_W     = 2;
  localparam int unsigned STALL_W     = 16;

  // Control bundle, MSB first: pc_write, if_id_write, if_flush, id_ex_bubble, pipe_hold, irq_ack
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_flush;
    logic id_ex_bubble;
    logic pipe_hold;
    logic irq_ack;
  } ctrl_t;

  localparam ctrl_t CTRL_RUN = ctrl_t'(6'b110000);

  // Saturating increment for the stall counter.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard comparator: a load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hazard = ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait, branch flush, interrupt entry and load-use stall.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// RUN          | normal issue; resolves mem wait > branch > irq > load-use
// MEM_WAIT     | memory access outstanding, pipeline frozen
// IRQ_DRAIN    | flushing front end while older instructions retire
// IRQ_ENTER    | one-cycle PC-to-vector strobe, then back to RUN
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic               sysclk,
  input  logic               reset,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rt,
  input  logic               ex_memread,
  input  logic [REG_W-1:0]   ex_rt,
  input  logic               ex_branch_taken,
  input  logic               irq_req,
  input  logic               mem_req,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               if_flush,
  output logic               id_ex_bubble,
  output logic               pipe_hold,
  output logic               irq_ack,
  output logic [STALL_W-1:0] stall_cnt,
  output logic [2:0]         state
);

  state_t             state_q, state_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [STALL_W-1:0] stall_q;
  logic               lu_q, lu_d;
  logic               load_use;
  logic               mem_stall;
  ctrl_t              ctrl;

  load_use_detect u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .hazard     (load_use)
  );

  assign mem_stall = mem_req && !mem_ready;

  // Next-state and control decode; outputs follow the inputs in the same cycle.
  always_comb begin
    ctrl    = CTRL_RUN;
    state_d = state_q;
    drain_d = drain_q;
    lu_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.pipe_hold   = 1'b1;
          state_d          = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
          ctrl.if_flush     = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
        end else if (irq_req) begin
          ctrl.pc_write     = 1'b0;
          ctrl.if_flush     = 1'b1;
          ctrl.id_ex_bubble = 1'b1;
          drain_d           = DRAIN_W'(DRAIN_DEPTH);
          state_d           = ST_IRQ_DRAIN;
        end else if (load_use && !lu_q) begin
          // The bubble we insert moves the load on, so a second stall is never needed.
          ctrl.pc_write     = 1'b0;
          ctrl.if_id_write  = 1'b0;
          ctrl.id_ex_bubble = 1'b1;
          lu_d              = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          ctrl.pc_write    = 1'b0;
          ctrl.if_id_write = 1'b0;
          ctrl.pipe_hold   = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_IRQ_DRAIN: begin
        ctrl.pc_write     = 1'b0;
        ctrl.if_flush     = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
        if (mem_stall) begin
          ctrl.pipe_hold = 1'b1;
        end else if (drain_q <= DRAIN_W'(1)) begin
          drain_d = '0;
          state_d = ST_IRQ_ENTER;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_IRQ_ENTER: begin
        ctrl.irq_ack      = 1'b1;
        ctrl.if_flush     = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
        state_d           = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
        drain_d = '0;
      end
    endcase
    // While reset is held the registers sit in RUN; keep the outputs at RUN defaults too.
    if (!reset) begin
      ctrl = CTRL_RUN;
    end
  end

  // State, drain counter and load-use stall memory.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      lu_q    <= lu_d;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (!ctrl.pc_write) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign if_flush     = ctrl.if_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_hold    = ctrl.pipe_hold;
  assign irq_ack      = ctrl.irq_ack;
  assign stall_cnt    = stall_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expectations, monitor compares each cycle.
module tb_pipeline_hazard_ctrl;

  logic        sysclk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        id_uses_rt = 1'b0, ex_memread = 1'b0, ex_branch_taken = 1'b0;
  logic        irq_req = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic        pc_write, if_id_write, if_flush, id_ex_bubble, pipe_hold, irq_ack;
  logic [15:0] stall_cnt;
  logic [2:0]  state;

  // {pc_write, if_id_write, if_flush, id_ex_bubble, pipe_hold, irq_ack}
  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_MEMH  = 6'b000010;
  localparam logic [5:0] C_BR    = 6'b111100;
  localparam logic [5:0] C_LU    = 6'b000100;
  localparam logic [5:0] C_DRN   = 6'b011100;
  localparam logic [5:0] C_DRNH  = 6'b011110;
  localparam logic [5:0] C_ENTER = 6'b111101;

  typedef struct {
    string       name;
    logic [5:0]  ctrl;
    logic [2:0]  st;
    logic [15:0] stall;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  pipeline_hazard_ctrl dut (
    .sysclk          (sysclk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_memread      (ex_memread),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .irq_req         (irq_req),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_flush        (if_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_hold       (pipe_hold),
    .irq_ack         (irq_ack),
    .stall_cnt       (stall_cnt),
    .state           (state)
  );

  always #5 sysclk = ~sysclk;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
  endfunction

  task automatic step(input string nm, input logic rst,
                      input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                      input logic mr, input logic [4:0] ert, input logic br, input logic irq,
                      input logic mreq, input logic mrdy,
                      input logic [5:0] ec, input logic [2:0] es, input logic [15:0] esc);
    exp_t e;
    @(posedge sysclk);
    #1;
    reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt; ex_memread = mr; ex_rt = ert;
    ex_branch_taken = br; irq_req = irq; mem_req = mreq; mem_ready = mrdy;
    e.name = nm; e.ctrl = ec; e.st = es; e.stall = esc;
    sb.push_back(e);
  endtask

  // Monitor: outputs are valid every cycle, compare mid-cycle against the oldest expectation.
  always @(negedge sysclk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, "_ctrl"}, 32'({pc_write, if_id_write, if_flush, id_ex_bubble, pipe_hold, irq_ack}), 32'(e.ctrl));
      check({e.name, "_state"}, 32'(state), 32'(e.st));
      check({e.name, "_stall"}, 32'(stall_cnt), 32'(e.stall));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  //                 name        rst rs  rt  urt mr ert br irq mrq mrdy ctrl     st    stall
  initial begin
    step("rst_a",     0, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("rst_b",     0, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_RUN,   3'd0, 16'd0);
    step("idle",      1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("lu_rs",     1, 8,  0,  0, 1, 8,  0, 0, 0, 0, C_LU,    3'd0, 16'd0);
    step("post_lu",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd1);
    step("r0_nolu",   1, 0,  0,  1, 1, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd1);
    step("lu_rt",     1, 3,  5,  1, 1, 5,  0, 0, 0, 0, C_LU,    3'd0, 16'd1);
    step("rt_unused", 1, 3,  5,  0, 1, 5,  0, 0, 0, 0, C_RUN,   3'd0, 16'd2);
    step("lu_hold_a", 1, 9,  0,  0, 1, 9,  0, 0, 0, 0, C_LU,    3'd0, 16'd2);
    step("lu_hold_b", 1, 9,  0,  0, 1, 9,  0, 0, 0, 0, C_RUN,   3'd0, 16'd3);
    step("br_lu",     1, 8,  0,  0, 1, 8,  1, 0, 0, 0, C_BR,    3'd0, 16'd3);
    step("br_irq",    1, 0,  0,  0, 0, 0,  1, 1, 0, 0, C_BR,    3'd0, 16'd3);
    step("irq_acc",   1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd0, 16'd3);
    step("drain3",    1, 0,  0,  0, 0, 0,  1, 1, 0, 0, C_DRN,   3'd2, 16'd4);
    step("drain2",    1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd2, 16'd5);
    step("drain1",    1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd2, 16'd6);
    step("enter",     1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_ENTER, 3'd3, 16'd7);
    step("post_ack",  1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd7);
    step("irq2_acc",  1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd0, 16'd7);
    step("drn_hold",  1, 0,  0,  0, 0, 0,  0, 1, 1, 0, C_DRNH,  3'd2, 16'd8);
    step("drn2_3",    1, 0,  0,  0, 0, 0,  0, 1, 1, 1, C_DRN,   3'd2, 16'd9);
    step("drn2_2",    1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd2, 16'd10);
    step("drn2_1",    1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd2, 16'd11);
    step("enter2",    1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_ENTER, 3'd3, 16'd12);
    step("post_ack2", 1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd12);
    step("mw_1",      1, 0,  0,  0, 0, 0,  0, 0, 1, 0, C_MEMH,  3'd0, 16'd12);
    step("mw_2",      1, 0,  0,  0, 0, 0,  0, 0, 1, 0, C_MEMH,  3'd1, 16'd13);
    step("mw_3",      1, 0,  0,  0, 0, 0,  0, 0, 1, 0, C_MEMH,  3'd1, 16'd14);
    step("mw_4",      1, 0,  0,  0, 0, 0,  0, 0, 1, 0, C_MEMH,  3'd1, 16'd15);
    step("mw_done",   1, 0,  0,  0, 0, 0,  0, 0, 1, 1, C_RUN,   3'd1, 16'd16);
    step("mw_after",  1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd16);
    step("prio_mem",  1, 8,  0,  0, 1, 8,  1, 1, 1, 0, C_MEMH,  3'd0, 16'd16);
    step("prio_rel",  1, 0,  0,  0, 0, 0,  0, 0, 1, 1, C_RUN,   3'd1, 16'd17);
    step("prio_idle", 1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd17);
    step("irq3_acc",  1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd0, 16'd17);
    step("irq3_drn",  1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd2, 16'd18);
    // Asynchronous reset in the middle of the drain.
    @(negedge sysclk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_stall", 32'(stall_cnt), 32'd0);
    check("rst_async_ack", 32'(irq_ack), 32'd0);
    step("rst_hold",  0, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_RUN,   3'd0, 16'd0);
    step("rst_rel",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("noack_1",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("noack_2",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("noack_3",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("noack_4",   1, 0,  0,  0, 0, 0,  0, 0, 0, 0, C_RUN,   3'd0, 16'd0);
    step("irq4_acc",  1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd0, 16'd0);
    step("irq4_drn",  1, 0,  0,  0, 0, 0,  0, 1, 0, 0, C_DRN,   3'd2, 16'd1);
    @(negedge sysclk);
    @(negedge sysclk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
